// File: rtl/ccff_mux.sv
// N-input routing mux fed by a configuration-chain segment. The shifted-in select
// is checked for length, parity and range before it replaces the committed select.
module ccff_mux #(
   parameter int N_IN         = 8,
   parameter int CHAIN_PARITY = 1,
   localparam int CFG_W       = $clog2(N_IN)
) (
   input  logic             prog_clk,
   input  logic             pReset_n,
   input  logic             ccff_en,
   input  logic             ccff_head,
   output logic             ccff_tail,
   input  logic [N_IN-1:0]  in,
   output logic             out,
   output logic [CFG_W-1:0] mem_out,
   output logic [CFG_W-1:0] mem_outb,
   output logic             cfg_valid,
   output logic             cfg_err,
   output logic             dbg_state
);

   localparam int L     = CFG_W + CHAIN_PARITY;
   localparam int CNT_W = $clog2(L + 1);
   localparam int PAD_W = 2 ** CFG_W;

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t           state;
   logic [L-1:0]     chain;
   logic [CNT_W-1:0] cnt;

   logic [L:0]       chain_ext;
   logic [L-1:0]     chain_nxt;
   logic [CFG_W-1:0] cand;
   logic             par_ok;
   logic             len_ok;
   logic             rng_ok;
   logic             accept;
   logic [PAD_W-1:0] in_pad;

   // The first bit shifted ends up in chain[L-1]; the last one in chain[0].
   always_comb begin
      chain_ext = {chain, ccff_head};
      chain_nxt = chain_ext[L-1:0];
   end

   always_comb begin
      cand   = chain[CFG_W-1:0];
      par_ok = (CHAIN_PARITY == 0) || (^chain == 1'b0);
      len_ok = (cnt == CNT_W'(L));
      rng_ok = (32'(cand) < N_IN);
      accept = par_ok && len_ok && rng_ok;
   end

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         state     <= IDLE;
         chain     <= '0;
         cnt       <= '0;
         mem_out   <= '0;
         cfg_valid <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ccff_en) begin
                  chain <= chain_nxt;
                  cnt   <= CNT_W'(1);
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (ccff_en) begin
                  chain <= chain_nxt;
                  // Saturate so overlong bursts still count as full-length.
                  if (cnt != CNT_W'(L)) cnt <= cnt + CNT_W'(1);
               end else begin
                  state <= IDLE;
                  cnt   <= '0;
                  if (accept) begin
                     mem_out   <= cand;
                     cfg_valid <= 1'b1;
                     cfg_err   <= 1'b0;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Padding lets mem_out index a power-of-two vector for any N_IN.
   assign in_pad    = PAD_W'(in);
   assign out       = cfg_valid & in_pad[mem_out];
   assign mem_outb  = ~mem_out;
   assign ccff_tail = chain[L-1];
   assign dbg_state = state;

endmodule

// File: tb/tb_ccff_mux.sv
// Directed bench for ccff_mux: an 8-input instance (L=4) plus a 6-input instance
// for the select range check.
module tb_ccff_mux;

   logic       prog_clk;
   logic       pReset_n;

   logic       en8, head8, tail8, out8, valid8, err8, st8;
   logic [7:0] in8;
   logic [2:0] mem8, memb8;

   logic       en6, head6, tail6, out6, valid6, err6, st6;
   logic [5:0] in6;
   logic [2:0] mem6, memb6;

   int n_checks = 0;
   int n_pass   = 0;

   ccff_mux #(.N_IN(8), .CHAIN_PARITY(1)) u_dut8 (
      .prog_clk (prog_clk),
      .pReset_n (pReset_n),
      .ccff_en  (en8),
      .ccff_head(head8),
      .ccff_tail(tail8),
      .in       (in8),
      .out      (out8),
      .mem_out  (mem8),
      .mem_outb (memb8),
      .cfg_valid(valid8),
      .cfg_err  (err8),
      .dbg_state(st8)
   );

   ccff_mux #(.N_IN(6), .CHAIN_PARITY(1)) u_dut6 (
      .prog_clk (prog_clk),
      .pReset_n (pReset_n),
      .ccff_en  (en6),
      .ccff_head(head6),
      .ccff_tail(tail6),
      .in       (in6),
      .out      (out6),
      .mem_out  (mem6),
      .mem_outb (memb6),
      .cfg_valid(valid6),
      .cfg_err  (err6),
      .dbg_state(st6)
   );

   // clock / reset
   initial prog_clk = 1'b0;
   always #5 prog_clk = ~prog_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // drivers: inputs change 1 time unit after the rising edge
   task automatic shift8(input logic b);
      en8 = 1'b1; head8 = b;
      @(posedge prog_clk); #1;
   endtask

   task automatic end8();
      en8 = 1'b0; head8 = 1'($urandom_range(0, 1));
      @(posedge prog_clk); #1;
   endtask

   task automatic shift6(input logic b);
      en6 = 1'b1; head6 = b;
      @(posedge prog_clk); #1;
   endtask

   task automatic end6();
      en6 = 1'b0;
      @(posedge prog_clk); #1;
   endtask

   task automatic check_reset8(input string tag);
      check({tag, "_out"},   32'(out8),   32'd0);
      check({tag, "_mem"},   32'(mem8),   32'd0);
      check({tag, "_memb"},  32'(memb8),  32'd7);
      check({tag, "_valid"}, 32'(valid8), 32'd0);
      check({tag, "_err"},   32'(err8),   32'd0);
      check({tag, "_tail"},  32'(tail8),  32'd0);
      check({tag, "_state"}, 32'(st8),    32'd0);
   endtask

   logic [7:0] pt_bits;

   initial begin
      en8 = 1'b0; head8 = 1'b0; in8 = '0;
      en6 = 1'b0; head6 = 1'b0; in6 = '0;

      // reset with random traffic on the inputs
      pReset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in8   = 8'($urandom_range(0, 255));
         head8 = 1'($urandom_range(0, 1));
         en8   = 1'($urandom_range(0, 1));
         @(posedge prog_clk); #1;
         check_reset8("rst");
      end
      en8 = 1'b0;
      pReset_n = 1'b1;
      @(posedge prog_clk); #1;

      // legal load: parity 0, sel 101
      in8 = 8'b0010_0000;
      shift8(1'b0);
      check("legal_state_shift", 32'(st8), 32'd1);
      shift8(1'b1); shift8(1'b0); shift8(1'b1);
      check("legal_out_preload", 32'(out8), 32'd0);
      check("legal_valid_pre", 32'(valid8), 32'd0);
      end8();
      check("legal_mem", 32'(mem8), 32'd5);
      check("legal_memb", 32'(memb8), 32'd2);
      check("legal_valid", 32'(valid8), 32'd1);
      check("legal_err", 32'(err8), 32'd0);
      check("legal_state_idle", 32'(st8), 32'd0);
      check("legal_out_hi", 32'(out8), 32'd1);
      in8 = 8'b1101_1111; #1;
      check("legal_out_lo", 32'(out8), 32'd0);

      // parity reject; out keeps following in[5] during the burst
      in8 = 8'b0010_0000;
      shift8(1'b1); check("par_out_s1", 32'(out8), 32'd1);
      shift8(1'b1); check("par_out_s2", 32'(out8), 32'd1);
      in8 = 8'b1101_1111;
      shift8(1'b0); check("par_out_s3", 32'(out8), 32'd0);
      shift8(1'b1); check("par_mem_s4", 32'(mem8), 32'd5);
      end8();
      check("par_err", 32'(err8), 32'd1);
      check("par_mem", 32'(mem8), 32'd5);
      check("par_valid", 32'(valid8), 32'd1);
      in8 = 8'b0010_0000; #1;
      check("par_out", 32'(out8), 32'd1);

      // short burst: only 2 bits
      shift8(1'b0); shift8(1'b1);
      end8();
      check("short_err", 32'(err8), 32'd1);
      check("short_mem", 32'(mem8), 32'd5);
      check("short_valid", 32'(valid8), 32'd1);

      // reset in the middle of a burst, asserted between edges
      shift8(1'b1); shift8(1'b1);
      #2 pReset_n = 1'b0;
      #1;
      check_reset8("midrst");
      en8 = 1'b0;
      @(posedge prog_clk); #1;
      pReset_n = 1'b1;
      @(posedge prog_clk); #1;
      check_reset8("postrst");

      // pass-through: 8-bit burst, tail shows first 4 bits before edges 5..8
      pt_bits = 8'b0110_1001;
      for (int i = 0; i < 8; i++) begin
         if (i >= 4) check($sformatf("pt_tail%0d", i + 1), 32'(tail8), 32'(pt_bits[7 - (i - 4)]));
         shift8(pt_bits[7 - i]);
      end
      check("pt_tail_last", 32'(tail8), 32'd1);
      end8();
      check("pt_mem", 32'(mem8), 32'd1);
      check("pt_valid", 32'(valid8), 32'd1);
      check("pt_err", 32'(err8), 32'd0);
      in8 = 8'b0000_0010; #1;
      check("pt_out_hi", 32'(out8), 32'd1);
      in8 = 8'b1111_1101; #1;
      check("pt_out_lo", 32'(out8), 32'd0);

      // range check on the 6-input instance: sel 111 has good parity but is out of range
      in6 = 6'b11_1111;
      shift6(1'b1); shift6(1'b1); shift6(1'b1); shift6(1'b1);
      end6();
      check("rng_err", 32'(err6), 32'd1);
      check("rng_valid", 32'(valid6), 32'd0);
      check("rng_mem", 32'(mem6), 32'd0);
      check("rng_out", 32'(out6), 32'd0);

      // highest legal select on the 6-input instance: sel 101, parity 0
      shift6(1'b0); shift6(1'b1); shift6(1'b0); shift6(1'b1);
      end6();
      check("rng5_mem", 32'(mem6), 32'd5);
      check("rng5_valid", 32'(valid6), 32'd1);
      check("rng5_err", 32'(err6), 32'd0);
      in6 = 6'b10_0000; #1;
      check("rng5_out_hi", 32'(out6), 32'd1);
      in6 = 6'b01_1111; #1;
      check("rng5_out_lo", 32'(out6), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
